cnd_prio_arb: RTL and testbench

Parametrised, registered successor to the team's one-hot priority case encoder. It selects one active request out of `N`, in either fixed-priority or round-robin order, and presents the result as an index plus a one-hot vector. The result is held under a valid/ready handshake until downstream accepts it. It sits between request-collecting logic and a single shared consumer, and replaces all `x` defaults with defined values so the block stays lint-clean.

---
 rtl/cnd_prio_arb.sv | 111 +++++++++++
 tb/tb_cnd_prio_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cnd_prio_arb.sv
// Registered N-way request arbiter, fixed-priority or round-robin, with a
// sticky valid/ready grant and index plus one-hot outputs.
module cnd_prio_arb #(
   parameter int unsigned N    = 4,
   parameter int unsigned MODE = 0,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             grant_ready,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic [N-1:0]     grant_onehot,
   output logic             busy_stall
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic             valid_d;
   logic [IDX_W-1:0] idx_d;
   logic [N-1:0]     oh_d;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] ptr_inc;
   logic [IDX_W-1:0] search_ptr;
   logic             accept_c;
   logic [2*N-1:0]   req_dbl;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [N-1:0]     win_oh;

   assign accept_c = (state_q == HOLD) && grant_ready;

   // Pointer advance wraps explicitly so non-power-of-two N never escapes 0..N-1.
   assign ptr_inc = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

   // An accept this cycle moves the pointer before the next winner is searched.
   assign search_ptr = (MODE == 1) ? (accept_c ? ptr_inc : ptr_q) : '0;

   assign req_dbl = {req, req};

   // Double-width masked search: first set bit at or above search_ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 0; i < 2 * N; i++) begin
         if (!win_found && req_dbl[i] && (i >= 32'(search_ptr))) begin
            win_found = 1'b1;
            win_idx   = IDX_W'((i >= N) ? (i - N) : i);
         end
      end
   end

   assign win_oh = N'(1) << win_idx;

   always_comb begin
      state_d = state_q;
      valid_d = grant_valid;
      idx_d   = grant_idx;
      oh_d    = grant_onehot;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = HOLD;
               valid_d = 1'b1;
               idx_d   = win_idx;
               oh_d    = win_oh;
            end
         end
         HOLD: begin
            // Without an accept the grant is sticky regardless of req.
            if (grant_ready) begin
               ptr_d = (MODE == 1) ? ptr_inc : '0;
               if (win_found) begin
                  idx_d = win_idx;
                  oh_d  = win_oh;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  idx_d   = '0;
                  oh_d    = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
         grant_onehot <= '0;
         ptr_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_valid  <= valid_d;
         grant_idx    <= idx_d;
         grant_onehot <= oh_d;
         ptr_q        <= ptr_d;
      end
   end

   assign busy_stall = grant_valid && !grant_ready;

endmodule

// File: tb/tb_cnd_prio_arb.sv
// Table-driven bench for cnd_prio_arb: N=4 fixed, N=4 round-robin, N=5 round-robin.
module tb_cnd_prio_arb;

   typedef struct {
      int         dut;
      logic       rst;
      logic [4:0] req;
      logic       rdy;
      logic       exp_valid;
      logic [2:0] exp_idx;
      logic [4:0] exp_oh;
      logic       exp_busy;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, rdy_a = 1'b0, gv_a, bs_a;
   logic [3:0] req_a = '0, go_a;
   logic [1:0] gi_a;

   logic       rst_b = 1'b1, rdy_b = 1'b0, gv_b, bs_b;
   logic [3:0] req_b = '0, go_b;
   logic [1:0] gi_b;

   logic       rst_c = 1'b1, rdy_c = 1'b0, gv_c, bs_c;
   logic [4:0] req_c = '0, go_c;
   logic [2:0] gi_c;

   cnd_prio_arb #(.N(4), .MODE(0)) u_a (
      .clk(clk), .rst(rst_a), .req(req_a), .grant_ready(rdy_a),
      .grant_valid(gv_a), .grant_idx(gi_a), .grant_onehot(go_a), .busy_stall(bs_a));

   cnd_prio_arb #(.N(4), .MODE(1)) u_b (
      .clk(clk), .rst(rst_b), .req(req_b), .grant_ready(rdy_b),
      .grant_valid(gv_b), .grant_idx(gi_b), .grant_onehot(go_b), .busy_stall(bs_b));

   cnd_prio_arb #(.N(5), .MODE(1)) u_c (
      .clk(clk), .rst(rst_c), .req(req_c), .grant_ready(rdy_c),
      .grant_valid(gv_c), .grant_idx(gi_c), .grant_onehot(go_c), .busy_stall(bs_c));

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t mk(input int d, input logic r, input logic [4:0] q,
                               input logic y, input logic ev, input logic [2:0] ei,
                               input logic [4:0] eo, input logic eb);
      vec_t v;
      v.dut = d; v.rst = r; v.req = q; v.rdy = y;
      v.exp_valid = ev; v.exp_idx = ei; v.exp_oh = eo; v.exp_busy = eb;
      return v;
   endfunction

   task automatic chk(input string nm, input int n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, n, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      case (v.dut)
         0: begin rst_a = v.rst; req_a = v.req[3:0]; rdy_a = v.rdy; end
         1: begin rst_b = v.rst; req_b = v.req[3:0]; rdy_b = v.rdy; end
         default: begin rst_c = v.rst; req_c = v.req; rdy_c = v.rdy; end
      endcase
   endtask

   task automatic compare(input vec_t e, input int n);
      logic       av, ab;
      logic [2:0] ai;
      logic [4:0] ao;
      case (e.dut)
         0: begin av = gv_a; ai = 3'(gi_a); ao = 5'(go_a); ab = bs_a; end
         1: begin av = gv_b; ai = 3'(gi_b); ao = 5'(go_b); ab = bs_b; end
         default: begin av = gv_c; ai = gi_c; ao = go_c; ab = bs_c; end
      endcase
      chk("grant_valid", n, 32'(av), 32'(e.exp_valid));
      chk("grant_idx", n, 32'(ai), 32'(e.exp_idx));
      chk("grant_onehot", n, 32'(ao), 32'(e.exp_oh));
      chk("busy_stall", n, 32'(ab), 32'(e.exp_busy));
   endtask

   initial begin
      // DUT A: N=4 fixed priority. Reset with requests pending, then priority order.
      tbl.push_back(mk(0, 1, 5'b01111, 0, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(0, 1, 5'b01111, 0, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(0, 0, 5'b01111, 0, 1, 0, 5'b00001, 1));
      tbl.push_back(mk(0, 0, 5'b01100, 1, 1, 2, 5'b00100, 0));
      tbl.push_back(mk(0, 0, 5'b01100, 1, 1, 2, 5'b00100, 0));
      tbl.push_back(mk(0, 0, 5'b01100, 1, 1, 2, 5'b00100, 0));
      tbl.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(0, 0, 5'b00010, 0, 1, 1, 5'b00010, 1));
      tbl.push_back(mk(0, 0, 5'b01000, 0, 1, 1, 5'b00010, 1));
      tbl.push_back(mk(0, 0, 5'b01000, 1, 1, 3, 5'b01000, 0));
      tbl.push_back(mk(0, 0, 5'b00000, 0, 1, 3, 5'b01000, 1));
      tbl.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 5'b00000, 0));
      // DUT B: N=4 round-robin rotation 0,1,3,0,1,3.
      tbl.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(1, 0, 5'b01011, 1, 1, 0, 5'b00001, 0));
      tbl.push_back(mk(1, 0, 5'b01011, 1, 1, 1, 5'b00010, 0));
      tbl.push_back(mk(1, 0, 5'b01011, 1, 1, 3, 5'b01000, 0));
      tbl.push_back(mk(1, 0, 5'b01011, 1, 1, 0, 5'b00001, 0));
      tbl.push_back(mk(1, 0, 5'b01011, 1, 1, 1, 5'b00010, 0));
      tbl.push_back(mk(1, 0, 5'b01011, 1, 1, 3, 5'b01000, 0));
      // Stall: grant 1 held five cycles while req toggles, then accept gives 2.
      tbl.push_back(mk(1, 0, 5'b00010, 1, 1, 1, 5'b00010, 0));
      tbl.push_back(mk(1, 0, 5'b00100, 0, 1, 1, 5'b00010, 1));
      tbl.push_back(mk(1, 0, 5'b00000, 0, 1, 1, 5'b00010, 1));
      tbl.push_back(mk(1, 0, 5'b00100, 0, 1, 1, 5'b00010, 1));
      tbl.push_back(mk(1, 0, 5'b00000, 0, 1, 1, 5'b00010, 1));
      tbl.push_back(mk(1, 0, 5'b00100, 0, 1, 1, 5'b00010, 1));
      tbl.push_back(mk(1, 0, 5'b00100, 1, 1, 2, 5'b00100, 0));
      // Reset mid-hold with ptr parked at 1: first post-reset grant must be 0.
      tbl.push_back(mk(1, 0, 5'b00011, 1, 1, 0, 5'b00001, 0));
      tbl.push_back(mk(1, 0, 5'b00011, 1, 1, 1, 5'b00010, 0));
      tbl.push_back(mk(1, 1, 5'b00011, 0, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(1, 0, 5'b00011, 0, 1, 0, 5'b00001, 1));
      tbl.push_back(mk(1, 0, 5'b00011, 1, 1, 1, 5'b00010, 0));
      // Ready while idle must not move ptr (ptr=2 here, so 0011 picks 0).
      tbl.push_back(mk(1, 0, 5'b00000, 1, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(1, 0, 5'b00000, 1, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(1, 0, 5'b00011, 0, 1, 0, 5'b00001, 1));
      // DUT C: N=5 round-robin wrap 0,4,0,4,0.
      tbl.push_back(mk(2, 1, 5'b00000, 0, 0, 0, 5'b00000, 0));
      tbl.push_back(mk(2, 0, 5'b10001, 1, 1, 0, 5'b00001, 0));
      tbl.push_back(mk(2, 0, 5'b10001, 1, 1, 4, 5'b10000, 0));
      tbl.push_back(mk(2, 0, 5'b10001, 1, 1, 0, 5'b00001, 0));
      tbl.push_back(mk(2, 0, 5'b10001, 1, 1, 4, 5'b10000, 0));
      tbl.push_back(mk(2, 0, 5'b10001, 1, 1, 0, 5'b00001, 0));
      // Ptr now 1: a lone request at 3 exercises a middle start point.
      tbl.push_back(mk(2, 0, 5'b01000, 1, 1, 3, 5'b01000, 0));
      tbl.push_back(mk(2, 0, 5'b01001, 1, 1, 0, 5'b00001, 0));

      @(negedge clk);
      for (int n = 0; n < tbl.size(); n++) begin
         vec_t e;
         apply(tbl[n]);
         sb.push_back(tbl[n]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         compare(e, n);
         @(negedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
